// File: rtl/alu_md.sv
// EX-stage datapath: combinational WIDTH-generic ALU plus an iterative
// multiply/divide engine that writes the HI/LO result registers.
module alu_md #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             ovf,
  input  logic [1:0]       md_op,
  input  logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] sum, diff, alu_d;
  logic [SHW-1:0]   shamt;
  logic             ovf_d;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = a[SHW-1:0];

  always_comb begin
    alu_d = '0;
    ovf_d = 1'b0;
    case (ctl)
      4'h0: alu_d = a & b;
      4'h1: alu_d = a | b;
      4'h2: begin
        alu_d = sum;
        ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'h3: alu_d = {{(WIDTH-1){1'b0}}, (a < b)};
      4'h4: alu_d = b << shamt;
      4'h5: alu_d = b >> shamt;
      4'h6: begin
        alu_d = diff;
        ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // Signed compare is done directly, not from diff's sign, so it holds on overflow.
      4'h7: alu_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'h8: alu_d = WIDTH'($signed(b) >>> shamt);
      4'hB: alu_d = a ^ b;
      4'hC: alu_d = ~(a | b);
      default: begin
        alu_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  assign out = alu_d;
  assign z   = (alu_d == '0);
  assign ovf = ovf_d;

  // ---------------- multiply/divide engine ----------------
  // Handshake: md_start is taken on any edge where md_busy is low (including
  // the md_done cycle); md_busy then stays high WIDTH+1 cycles, and md_done
  // pulses for one cycle alongside the hi/lo update. Starts while busy are dropped.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q;
  logic [SHW-1:0]     cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q, rneg_q, div0_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign signed_op = ~md_op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Accumulator holds {partial, multiplier} for multiply, {remainder, dividend/quotient} for divide.
  logic [WIDTH:0]       mul_sum, rem_sh, trial;
  logic [2*WIDTH-1:0]   acc_step;

  always_comb begin
    mul_sum  = '0;
    rem_sh   = '0;
    trial    = '0;
    acc_step = acc_q;
    if (op_q[1]) begin
      rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, mcand_q};
      if (!trial[WIDTH])
        acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  // Divide by zero ends with the remainder equal to the dividend, so only lo needs forcing.
  assign quo_fix  = div0_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
  assign rem_fix  = rneg_q ? -rem : rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (md_start && !busy_q) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            op_q    <= md_op;
            mcand_q <= b_mag;
            acc_q   <= {{WIDTH{1'b0}}, a_mag};
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            div0_q  <= (b == '0);
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER)
            state_q <= S_FIX;
        end
        S_FIX: begin
          if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md at WIDTH=32: directed ALU vectors, mul/div results checked
// against a reference model through an expected-result queue, handshake and reset.
module tb_alu_md;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   ctl;
  logic [W-1:0] a, b, out, hi, lo;
  logic         z, ovf;
  logic [1:0]   md_op;
  logic         md_start, md_busy, md_done;

  logic [2*W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ctl(ctl), .a(a), .b(b), .out(out), .z(z),
    .ovf(ovf), .md_op(md_op), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .hi(hi), .lo(lo)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      2'd0: return 64'(sx * sy);
      2'd1: return 64'(ux * uy);
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (md_done) begin
      done_cnt++;
      if (exp_q.size() == 0)
        check("exp_q_empty_at_done", 64'(exp_q.size()), 64'd1);
      else
        check("hilo", {hi, lo}, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic alu_chk(input string tag, input logic [3:0] c, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] e_out, input logic e_ovf);
    ctl = c; a = x; b = y;
    #1;
    check({tag, "_out"}, 64'(out), 64'(e_out));
    check({tag, "_z"},   64'(z),   64'(e_out == 32'd0));
    check({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
  endtask

  // Called at a negedge; start is seen on the next posedge, returns one negedge later.
  task automatic md_issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y, input bit push);
    md_op = op; a = x; b = y; md_start = 1'b1;
    if (push) exp_q.push_back(model(op, x, y));
    @(negedge clk);
    md_start = 1'b0;
    md_op = 2'($urandom_range(0, 3));
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!md_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("md_done_timeout", 64'(md_done), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt, dc;
    logic [31:0] x, y;
    logic [1:0]  op;

    reset = 1'b1; md_start = 1'b0; md_op = '0; ctl = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(md_busy), 64'd0);
    check("rst_done", 64'(md_done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    alu_chk("add_ovf",  4'h2, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1);
    alu_chk("add",      4'h2, 32'd100,       32'd23,        32'd123,       1'b0);
    alu_chk("sub_zero", 4'h6, 32'd5,         32'd5,         32'd0,         1'b0);
    alu_chk("sub_ovf",  4'h6, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1);
    alu_chk("slt",      4'h7, 32'h8000_0000, 32'h1,         32'd1,         1'b0);
    alu_chk("slt_vf",   4'h7, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
    alu_chk("sltu",     4'h3, 32'h8000_0000, 32'h1,         32'd0,         1'b0);
    alu_chk("sltu_lt",  4'h3, 32'h1,         32'h8000_0000, 32'd1,         1'b0);
    alu_chk("sra",      4'h8, 32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0);
    alu_chk("srl",      4'h5, 32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0);
    alu_chk("sll_mask", 4'h4, 32'h24,        32'h1,         32'h10,        1'b0);
    alu_chk("and",      4'h0, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, 1'b0);
    alu_chk("or",       4'h1, 32'hF0F0_0000, 32'h0F00_000F, 32'hFFF0_000F, 1'b0);
    alu_chk("xor",      4'hB, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
    alu_chk("nor",      4'hC, 32'hAAAA_0000, 32'h5555_000F, 32'h0000_FFF0, 1'b0);
    alu_chk("undef",    4'hF, 32'h7FFF_FFFF, 32'h1,         32'd0,         1'b0);

    // MULT -3 * 7 with busy length measurement
    @(negedge clk);
    md_issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
    busy_cnt = 0;
    while (md_busy && busy_cnt < 100) begin
      busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("done_after_busy", 64'(md_done), 64'd1);
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    check("done_one_cycle", 64'(md_done), 64'd0);

    md_issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    check("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    @(negedge clk);
    md_issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done();
    check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    @(negedge clk);
    md_issue(2'd3, 32'd100, 32'd0, 1'b1);
    wait_done();
    check("divu_zero_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

    @(negedge clk);
    md_issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    check("div_min_neg1", {hi, lo}, 64'h0000_0000_8000_0000);

    @(negedge clk);
    md_issue(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b1);
    wait_done();

    // start during busy must be dropped
    @(negedge clk);
    dc = done_cnt;
    md_issue(2'd1, 32'd12345, 32'd678, 1'b1);
    repeat (5) @(negedge clk);
    md_op = 2'd3; a = 32'd999; b = 32'd7; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    wait_done();
    check("busy_start_result", {hi, lo}, 64'd12345 * 64'd678);
    repeat (40) @(negedge clk);
    check("busy_start_ignored", 64'(done_cnt - dc), 64'd1);

    // back-to-back start in the md_done cycle
    md_issue(2'd2, 32'd1000, 32'hFFFF_FFFD, 1'b1);
    wait_done();
    md_issue(2'd3, 32'hDEAD_BEEF, 32'd1234, 1'b1);
    check("b2b_accepted", 64'(md_busy), 64'd1);
    wait_done();

    // reset during a divide
    @(negedge clk);
    dc = done_cnt;
    md_issue(2'd3, 32'h1234_5678, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(md_busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    repeat (45) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);

    // random operations
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i % 4 == 3) ? 32'($urandom_range(0, 5)) : $urandom;
      md_issue(op, x, y, 1'b1);
      wait_done();
      @(negedge clk);
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised next-generation datapath ALU for the MIPS core.
- Combinational integer unit, now WIDTH-generic, with shifts, unsigned compare and an exported overflow flag.
- Adds an iterative multiply/divide engine with HI/LO result registers and a start/busy/done handshake.
- Sits in the EX stage; the control unit stalls the pipeline on md_busy.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ctl  in  4  ALU operation select.
- a, b  in  WIDTH  operands, shared by ALU and mul/div.
- out  out  WIDTH  ALU result (combinational).
- z  out  1  high when out == 0.
- ovf  out  1  signed overflow of add (ctl 2) or sub (ctl 6); 0 for all other ops.
- md_op  in  2  0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- md_start  in  1  request a mul/div on a, b, md_op.
- md_busy  out  1  engine running.
- md_done  out  1  one-cycle pulse when hi/lo are updated.
- hi, lo  out  WIDTH  HI/LO result registers.

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and reset.
- Reset values: md_busy=0, md_done=0, hi=0, lo=0, FSM in IDLE, iteration counter=0.
- ALU is purely combinational. ctl encoding:
  - 0 and, 1 or, 2 add, 3 sltu, 4 sll, 5 srl, 6 sub, 7 slt, 8 sra, b xor, c nor.
  - Any other code gives out=0 and ovf=0.
- Shifts shift b by a[SHW-1:0].
- slt result is (a<b signed), zero-extended to WIDTH; it must stay correct when a-b overflows.
- sltu result is (a<b unsigned), zero-extended.
- ovf for add and sub: operands have the same sign (for sub, a and ~b) and the result sign differs.
- Mul/div FSM states:
  - IDLE -> RUN on md_start && !md_busy. At that edge, latch md_op, a and b; for signed ops, latch the operand magnitudes and result sign(s).
  - RUN: WIDTH iterations, one per clock.
    - Multiply is radix-2 shift-add into a 2*WIDTH-bit accumulator.
    - Divide is restoring, producing a quotient bit per cycle.
  - RUN -> FIX after WIDTH iterations.
  - FIX: apply sign correction. Quotient is negated if the operand signs differ; remainder takes the dividend's sign. Then write hi/lo, pulse md_done and return to IDLE.
- Latency: start accepted at edge N gives md_busy=1 from N through edge N+WIDTH+1. hi/lo are valid and md_done=1 in the cycle after edge N+WIDTH+1. Total is WIDTH+1 busy cycles.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero: hi = dividend (as given), lo = all ones. Same latency, no exception.
- Signed DIV of MIN by -1: lo=MIN, hi=0.
- md_start while busy is ignored. md_start in the md_done cycle is accepted, so back-to-back operations are possible.
- a, b and md_op may change freely after acceptance.
- hi/lo hold their value until the next completion or reset. There is no write port.
- Reset asserted mid-operation aborts the operation: IDLE, busy=0, no md_done pulse, hi=lo=0.
- The ALU path is unaffected by engine state.

Test Plan (WIDTH=32):
- ALU sweep:
  - add 0x7FFFFFFF+1 -> out 0x80000000, ovf=1.
  - sub 5-5 -> out 0, z=1, ovf=0.
  - slt 0x80000000 vs 1 -> 1; sltu same operands -> 0.
  - sra b=0x80000000 by a=4 -> 0xF8000000.
  - ctl=0xF -> out 0.
- MULT a=-3 (0xFFFFFFFD), b=7:
  - md_busy high exactly 33 cycles, then md_done for one cycle.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF.
- Handshake and reset:
  - md_start pulsed during busy is ignored; hi/lo reflect only the first operation.
  - A start in the md_done cycle is accepted back-to-back.
  - reset at cycle 10 of a divide -> busy=0, hi=lo=0, no md_done pulse.
